// File: rtl/shift_reg_seq_pkg.sv
// shift_reg_seq_pkg
//   Shared types and constants for the shift_reg_seq serializer/deserializer.
//   - state_t : transfer FSM encoding (IDLE / SHIFT / DONE)
//   - DIR_LEFT / DIR_RIGHT : values of the dir input
package shift_reg_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_reg_seq_bit_counter.sv
// sr_bit_counter
//   Counts shifts of one transfer and flags the shift that completes it.
//   Ports:
//     clk  in  1      rising-edge clock
//     clr  in  1      synchronous clear (wins over en)
//     en   in  1      count one shift
//     cnt  out CNT_W  shifts completed so far
//     tc   out 1      high on the enabled cycle whose shift makes cnt reach WIDTH
module sr_bit_counter
  import shift_reg_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tc = en && (cnt == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/shift_reg_seq.sv
// shift_reg_seq
//   Parallel-load / serial-in / serial-out shift register with selectable
//   direction and a small FSM that tracks a WIDTH-bit transfer.
//   Optional feature macro: SHIFT_ROT_EN (rot=1 recirculates the outgoing bit).
//   Ports:
//     clk      in  1      rising-edge clock
//     reset    in  1      synchronous, active-high
//     ld       in  1      load pd_in and start a transfer
//     pd_in    in  WIDTH  parallel load data
//     sh_en    in  1      shift enable (0 stalls the transfer)
//     dir      in  1      0 = left (MSB out), 1 = right (LSB out)
//     d_in     in  1      serial input
//     rot      in  1      rotate request (ignored unless SHIFT_ROT_EN)
//     out      out 1      serial output bit
//     pd_out   out WIDTH  register contents
//     busy     out 1      transfer in progress
//     done     out 1      one-cycle completion pulse
//     bit_cnt  out CNT_W  shifts completed in the current transfer
//
//   state  | meaning
//   IDLE   | no transfer; waiting for ld
//   SHIFT  | transfer in progress; shifting on sh_en
//   DONE   | WIDTH shifts finished; done pulse for one cycle
module shift_reg_seq
  import shift_reg_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld,
  input  logic [WIDTH-1:0] pd_in,
  input  logic             sh_en,
  input  logic             dir,
  input  logic             d_in,
  input  logic             rot,
  output logic             out,
  output logic [WIDTH-1:0] pd_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] bit_cnt
);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] q;
  logic             shout;
  logic             sin;
  logic             shift_go;
  logic             cnt_clr;
  logic             tc;

  assign shout = (dir == DIR_RIGHT) ? q[0] : q[WIDTH-1];

`ifdef SHIFT_ROT_EN
  assign sin = rot ? shout : d_in;
`else
  logic unused_rot;
  assign unused_rot = rot;
  assign sin        = d_in;
`endif

  // ld outranks shifting, so a reload in SHIFT never also advances the count.
  assign shift_go = (state == ST_SHIFT) && sh_en && !ld;
  // DONE always leaves the counter at zero: either IDLE or a fresh transfer follows.
  assign cnt_clr  = reset || ld || (state == ST_DONE);

  sr_bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk (clk),
    .clr (cnt_clr),
    .en  (shift_go),
    .cnt (bit_cnt),
    .tc  (tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (ld) begin
      q <= pd_in;
    end else if (shift_go) begin
      if (dir == DIR_RIGHT) q <= {sin, q[WIDTH-1:1]};
      else                  q <= {q[WIDTH-2:0], sin};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (ld) state_nxt = ST_SHIFT;
      ST_SHIFT: if (!ld && tc) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ld ? ST_SHIFT : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign out    = shout;
  assign pd_out = q;
  assign busy   = (state == ST_SHIFT);
  assign done   = (state == ST_DONE);

endmodule

// File: tb/tb_shift_reg_seq.sv
module tb_shift_reg_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ld = 1'b0;
  logic [3:0] pd_in = 4'b0000;
  logic       sh_en = 1'b0;
  logic       dir = 1'b0;
  logic       d_in = 1'b0;
  logic       rot = 1'b0;
  logic       out;
  logic [3:0] pd_out;
  logic       busy;
  logic       done;
  logic [2:0] bit_cnt;

  int checks = 0;
  int errors = 0;

  logic       exp_bits[$];
  logic [3:0] exp_words[$];

  shift_reg_seq #(.WIDTH(4), .CNT_W(3)) dut (
    .clk     (clk),
    .reset   (reset),
    .ld      (ld),
    .pd_in   (pd_in),
    .sh_en   (sh_en),
    .dir     (dir),
    .d_in    (d_in),
    .rot     (rot),
    .out     (out),
    .pd_out  (pd_out),
    .busy    (busy),
    .done    (done),
    .bit_cnt (bit_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_bits(input logic [3:0] b);
    for (int i = 3; i >= 0; i--) exp_bits.push_back(b[i]);
  endtask

  // Monitor: a bit is consumed on every edge that shifts; a word is presented with done.
  always @(negedge clk) begin
    if (!reset) begin
      if (busy && sh_en && !ld) begin
        if (exp_bits.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_shift: out=%0b with no expected bit at %0t", out, $time);
        end else begin
          chk("serial_out", {31'd0, out}, {31'd0, exp_bits.pop_front()});
        end
      end
      if (done) begin
        if (exp_words.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: pd_out=%0b with no expected word at %0t", pd_out, $time);
        end else begin
          chk("done_word", {28'd0, pd_out}, {28'd0, exp_words.pop_front()});
          chk("done_bit_cnt", {29'd0, bit_cnt}, 32'd4);
          chk("done_busy", {31'd0, busy}, 32'd0);
        end
      end
    end
  end

  initial begin
    repeat (5000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  logic       d_seq[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
  logic [3:0] rot_exp[4];

  initial begin
    // 1: reset with ld asserted
    reset = 1'b1; ld = 1'b1; pd_in = 4'b1111; sh_en = 1'b1;
    cyc(); cyc();
    chk("rst_pd_out", {28'd0, pd_out}, 32'h0);
    chk("rst_out", {31'd0, out}, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'h0);
    chk("rst_done", {31'd0, done}, 32'h0);
    chk("rst_bit_cnt", {29'd0, bit_cnt}, 32'h0);
    reset = 1'b0; ld = 1'b0; sh_en = 1'b0;
    cyc();

    // 2: left serialize 1011
    pd_in = 4'b1011; dir = 1'b0; d_in = 1'b0; sh_en = 1'b1; ld = 1'b1;
    push_bits(4'b1011); exp_words.push_back(4'b0000);
    cyc();
    ld = 1'b0;
    chk("t2_first_bit_after_ld", {31'd0, out}, 32'd1);
    repeat (4) cyc();
    chk("t2_done", {31'd0, done}, 32'd1);
    cyc();
    chk("t2_idle_cnt", {29'd0, bit_cnt}, 32'd0);
    chk("t2_idle_done", {31'd0, done}, 32'd0);
    cyc(); cyc();
    chk("idle_ignores_sh_en", {28'd0, pd_out}, 32'h0);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // 3: right shift, deserialize d_in
    pd_in = 4'b1011; dir = 1'b1; ld = 1'b1;
    exp_bits.push_back(1'b1); exp_bits.push_back(1'b1);
    exp_bits.push_back(1'b0); exp_bits.push_back(1'b1);
    exp_words.push_back(4'b1001);
    cyc();
    ld = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d_in = d_seq[i];
      cyc();
    end
    d_in = 1'b0;
    cyc();

    // 4: stall mid-transfer, then back-to-back load from DONE
    pd_in = 4'b1011; dir = 1'b0; ld = 1'b1; sh_en = 1'b1;
    push_bits(4'b1011); exp_words.push_back(4'b0000);
    cyc();
    ld = 1'b0;
    cyc(); cyc();
    sh_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("t4_stall_q", {28'd0, pd_out}, 32'b1100);
      chk("t4_stall_cnt", {29'd0, bit_cnt}, 32'd2);
      chk("t4_stall_no_done", {31'd0, done}, 32'd0);
    end
    sh_en = 1'b1;
    cyc();
    chk("t4_not_yet_done", {31'd0, done}, 32'd0);
    cyc();
    chk("t4_done", {31'd0, done}, 32'd1);
    ld = 1'b1; pd_in = 4'b0101;
    push_bits(4'b0101); exp_words.push_back(4'b0000);
    cyc();
    ld = 1'b0;
    chk("t4_b2b_busy", {31'd0, busy}, 32'd1);
    chk("t4_b2b_cnt", {29'd0, bit_cnt}, 32'd0);
    chk("t4_b2b_q", {28'd0, pd_out}, 32'b0101);
    repeat (4) cyc();
    cyc();

    // 5: reset aborts after two shifts; then ld+sh_en together
    pd_in = 4'b1011; ld = 1'b1;
    exp_bits.push_back(1'b1); exp_bits.push_back(1'b0);
    cyc();
    ld = 1'b0;
    cyc(); cyc();
    sh_en = 1'b0; reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("t5_rst_q", {28'd0, pd_out}, 32'h0);
    chk("t5_rst_busy", {31'd0, busy}, 32'd0);
    chk("t5_rst_cnt", {29'd0, bit_cnt}, 32'd0);
    sh_en = 1'b1;
    repeat (6) cyc();
    pd_in = 4'b1011; ld = 1'b1;
    exp_bits.push_back(1'b1);
    cyc();
    ld = 1'b0;
    cyc();
    pd_in = 4'b0110; ld = 1'b1;
    push_bits(4'b0110); exp_words.push_back(4'b0000);
    cyc();
    ld = 1'b0;
    chk("t5_ld_wins_cnt", {29'd0, bit_cnt}, 32'd0);
    chk("t5_ld_wins_q", {28'd0, pd_out}, 32'b0110);
    repeat (4) cyc();
    cyc();

    // 6: rotate request
`ifdef SHIFT_ROT_EN
    rot_exp = '{4'b0111, 4'b1110, 4'b1101, 4'b1011};
    exp_words.push_back(4'b1011);
`else
    rot_exp = '{4'b0110, 4'b1100, 4'b1000, 4'b0000};
    exp_words.push_back(4'b0000);
`endif
    rot = 1'b1; d_in = 1'b0; dir = 1'b0; pd_in = 4'b1011; ld = 1'b1;
    push_bits(4'b1011);
    cyc();
    ld = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("t6_rot_q", {28'd0, pd_out}, {28'd0, rot_exp[i]});
    end
    chk("t6_done", {31'd0, done}, 32'd1);
    rot = 1'b0; sh_en = 1'b0;
    cyc(); cyc();

    chk("bits_drained", exp_bits.size(), 32'd0);
    chk("words_drained", exp_words.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
